regfile_seq: RTL and testbench
==============================

# regfile_seq

Microcode sequencer for the 4-bit register file: holds a 16-word microprogram and, once started, issues one register-file `instr`/`imm` pair per clock. It supports jumps, zero-flag branches and a counted loop, then signals completion. It sits between the top-level control FSM (start/done) and the register file's `instr`/`imm` inputs. It observes the data bus to derive a zero flag.

## Interface
Parameters:
- `IDLE_INSTR`, default 4'h0: register-file no-operation code driven whenever no EXEC is active.
- `PW`, default 12: microword width. Fixed layout `{op[11:8], fa[7:4], fb[3:0]}`.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `grst`  in  1  reset, asynchronous, active-low.
- `start`  in  1  begin execution at address 0; honoured only in IDLE.
- `abort`  in  1  synchronous; RUN to IDLE next edge; no `done` pulse.
- `prog_we`  in  1  program-store write strobe; honoured only in IDLE.
- `prog_addr`  in  4  program-store write address.
- `prog_data`  in  12  program-store write data.
- `bus_in`  in  4  sampled copy of the register-file data bus.
- `instr`  out  4  to register file instruction input.
- `imm`  out  4  to register file immediate input.
- `busy`  out  1  high in RUN.
- `done`  out  1  one-cycle pulse after HALT.
- `pc`  out  4  current microprogram address (debug).

## Operation
- States: IDLE, RUN, DONE.
- Transitions:
  - IDLE→RUN on `start`, with `pc`=0.
  - RUN→DONE on HALT.
  - RUN→IDLE on `abort`; `abort` has priority over the current word's effect on `pc`, `cnt` and `zflag`.
  - DONE→IDLE unconditionally.
- Program store:
  - 16×12 register array.
  - Write in IDLE only; writes in RUN/DONE are ignored.
  - Read is asynchronous at `pc`.
- Opcodes, decoded from `op` in RUN:
  - 0 NOP: `pc`+1.
  - 1 EXEC: `instr`=fa, `imm`=fb, `pc`+1; `zflag`<=(`bus_in`==0) at end of cycle.
  - 2 JMP: `pc`<=fb.
  - 3 JZ: `pc`<=fb if `zflag`, else `pc`+1.
  - 4 LDC: `cnt`<=fb, `pc`+1.
  - 5 DJNZ: `cnt`<=`cnt`-1 (4-bit wrap); if `cnt`-1≠0 then `pc`<=fb, else `pc`+1.
  - F HALT: `pc` holds.
  - 6–E: treated as NOP.
- Outputs outside EXEC (any state, any other opcode): `instr`=`IDLE_INSTR`, `imm`=0.
- Width and boundary rules:
  - `pc`+1 wraps 15→0.
  - DJNZ with `cnt`=0 wraps to 15 and branches.
  - `zflag` and `cnt` persist across runs; they are cleared only by reset.

## Timing
- Reset values:
  - state IDLE, `pc`=0, `cnt`=0, `zflag`=0.
  - `busy`=0, `done`=0, `instr`=`IDLE_INSTR`, `imm`=0.
  - All program words = 12'hF00 (HALT).
- Start latency: `start` sampled high at edge N; word 0 is presented during cycle N+1.
- Issue rate: one microword per cycle, no stalls. `instr`/`imm` are combinational from the store and `pc`; the register file acts on the edge ending the cycle.
- HALT: HALT in cycle K puts DONE, with `done`=1 and `busy`=0, in cycle K+1; IDLE follows in K+2. A new `start` is accepted from K+2.
- Simultaneous `prog_we` and `start` in IDLE: the write commits at the same edge as the start, so the new word is visible at RUN.
- `start` during RUN or DONE is ignored. `abort` in IDLE or DONE is ignored.
- Reset asserted mid-run: immediate return to the reset values above, including the program store.

## Structure
- Package `regfile_seq_pkg`:
  - opcode constants (`OP_NOP`…`OP_HALT`);
  - state encoding;
  - microword field positions;
  - HALT fill word 12'hF00.
- Sub-module `regfile_seq_store`: 16×12 program array with reset fill, write port and asynchronous read port.
- Top module holds FSM, `pc`, `cnt`, `zflag` and output decode.

## Test plan
- Reset, then `start` with no programming → `done` pulse two cycles after `start`; `instr` stays `IDLE_INSTR` throughout.
- Program {EXEC 3,5; EXEC 6,2; HALT}, start → `instr`/`imm` = 3/5 then 6/2 on consecutive cycles; `done` one cycle after HALT; `busy` high exactly 3 cycles.
- Program {LDC 3; EXEC 1,0 at addr 1; DJNZ 1; HALT} → EXEC issued exactly 3 times; `cnt`=0 at `done`.
- EXEC with `bus_in`=0, then JZ 7 → `pc`=7. Repeat with `bus_in`=4'h9 → `pc` advances by 1.
- `abort` mid-loop → IDLE next edge, no `done`; a `prog_we` issued in RUN leaves the store unchanged.
- `grst` low mid-run → outputs at reset values immediately; program store reads back as all 12'hF00.

Source files
------------

// File: rtl/regfile_seq_pkg.sv
// regfile_seq_pkg: opcodes, state encoding, microword fields and HALT fill word for regfile_seq
package regfile_seq_pkg;
  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_EXEC = 4'h1;
  localparam logic [3:0] OP_JMP  = 4'h2;
  localparam logic [3:0] OP_JZ   = 4'h3;
  localparam logic [3:0] OP_LDC  = 4'h4;
  localparam logic [3:0] OP_DJNZ = 4'h5;
  localparam logic [3:0] OP_HALT = 4'hF;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam int OP_LSB = 8;
  localparam int FA_LSB = 4;
  localparam int FB_LSB = 0;
  localparam logic [11:0] HALT_WORD = 12'hF00;
endpackage

// File: rtl/regfile_seq_store.sv
// regfile_seq_store: 16-word program store, reset-filled with HALT, one write port, async read at raddr
module regfile_seq_store
  import regfile_seq_pkg::*;
#(
  parameter int PW = 12
) (
  input  logic          clk,
  input  logic          grst,
  input  logic          we,
  input  logic [3:0]    waddr,
  input  logic [PW-1:0] wdata,
  input  logic [3:0]    raddr,
  output logic [PW-1:0] rdata
);
  logic [PW-1:0] mem [16];
  always_ff @(posedge clk or negedge grst)
    if (!grst) for (int i = 0; i < 16; i++) mem[i] <= PW'(HALT_WORD);
    else if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/regfile_seq.sv
// regfile_seq: microcode sequencer issuing one instr/imm pair per cycle with jumps, zero branches and a counted loop
module regfile_seq
  import regfile_seq_pkg::*;
#(
  parameter logic [3:0] IDLE_INSTR = 4'h0,
  parameter int         PW         = 12
) (
  input  logic          clk,
  input  logic          grst,
  input  logic          start,
  input  logic          abort,
  input  logic          prog_we,
  input  logic [3:0]    prog_addr,
  input  logic [PW-1:0] prog_data,
  input  logic [3:0]    bus_in,
  output logic [3:0]    instr,
  output logic [3:0]    imm,
  output logic          busy,
  output logic          done,
  output logic [3:0]    pc
);
  logic [1:0] state;
  logic [3:0] cnt, cnt_dec, op, fa, fb, pc_nx;
  logic zflag, run, exec;
  logic [PW-1:0] word;
  regfile_seq_store #(.PW(PW)) u_store (
    .clk   (clk),
    .grst  (grst),
    .we    (prog_we && state == S_IDLE),
    .waddr (prog_addr),
    .wdata (prog_data),
    .raddr (pc),
    .rdata (word)
  );
  always_comb begin
    op      = word[OP_LSB +: 4];
    fa      = word[FA_LSB +: 4];
    fb      = word[FB_LSB +: 4];
    run     = state == S_RUN;
    exec    = run && op == OP_EXEC;
    cnt_dec = cnt - 4'd1;
    pc_nx   = (op == OP_JMP || (op == OP_JZ && zflag) || (op == OP_DJNZ && cnt_dec != 4'd0)) ? fb :
              op == OP_HALT ? pc : pc + 4'd1;
    instr   = exec ? fa : IDLE_INSTR;
    imm     = exec ? fb : 4'd0;
    busy    = run;
    done    = state == S_DONE;
  end
  always_ff @(posedge clk or negedge grst)
    if (!grst) begin
      state <= S_IDLE;
      pc    <= 4'd0;
      cnt   <= 4'd0;
      zflag <= 1'b0;
    end else if (state == S_IDLE) begin
      if (start) begin
        state <= S_RUN;
        pc    <= 4'd0;
      end
    end else if (state == S_DONE) state <= S_IDLE;
    else if (abort) state <= S_IDLE;
    else begin
      state <= op == OP_HALT ? S_DONE : S_RUN;
      pc    <= pc_nx;
      if (op == OP_LDC) cnt <= fb;
      else if (op == OP_DJNZ) cnt <= cnt_dec;
      if (exec) zflag <= bus_in == 4'd0;
    end
endmodule

// File: tb/tb_regfile_seq.sv
// tb_regfile_seq: scoreboard bench for regfile_seq with directed microprograms
module tb_regfile_seq;
  localparam logic [3:0] IDL = 4'hA;
  logic clk = 1'b0, grst = 1'b0, start = 1'b0, abort = 1'b0, prog_we = 1'b0;
  logic [3:0] prog_addr = 4'd0, bus_in = 4'd0;
  logic [11:0] prog_data = 12'd0;
  logic [3:0] instr, imm, pc;
  logic busy, done;
  int passed = 0, total = 0;
  int d_at, b_n;
  logic [3:0] p_d;
  typedef struct packed {logic d; logic [3:0] i; logic [3:0] m;} ev_t;
  ev_t sb[$];
  always #5 clk = ~clk;
  regfile_seq #(.IDLE_INSTR(IDL), .PW(12)) dut (
    .clk       (clk),
    .grst      (grst),
    .start     (start),
    .abort     (abort),
    .prog_we   (prog_we),
    .prog_addr (prog_addr),
    .prog_data (prog_data),
    .bus_in    (bus_in),
    .instr     (instr),
    .imm       (imm),
    .busy      (busy),
    .done      (done),
    .pc        (pc)
  );
  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask
  function automatic ev_t ex(input logic [3:0] i, input logic [3:0] m);
    return '{1'b0, i, m};
  endfunction
  function automatic ev_t dn();
    return '{1'b1, IDL, 4'h0};
  endfunction
  always @(negedge clk)
    if (grst === 1'b1 && (instr !== IDL || imm !== 4'h0 || done !== 1'b0)) begin
      ev_t e;
      if (sb.size() == 0) begin
        total++;
        $display("FAIL unexpected_out: got done=%b instr=%h imm=%h expected no output", done, instr, imm);
      end else begin
        e = sb.pop_front();
        chk("sb_done", 16'(done), 16'(e.d));
        chk("sb_instr", 16'(instr), 16'(e.i));
        chk("sb_imm", 16'(imm), 16'(e.m));
      end
    end
  task automatic prog(input logic [3:0] a, input logic [11:0] d);
    prog_we = 1'b1;
    prog_addr = a;
    prog_data = d;
    @(posedge clk); #1;
    prog_we = 1'b0;
  endtask
  task automatic run(output int done_at, output int busy_n, output logic [3:0] pc_done);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    done_at = 0;
    busy_n = 0;
    pc_done = 4'd0;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      if (busy) busy_n++;
      if (done) begin
        done_at = k;
        pc_done = pc;
        break;
      end
    end
    @(posedge clk); #1;
  endtask
  task automatic abort_run();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    chk("abort_busy", 16'(busy), 16'd0);
    chk("abort_pc", 16'(pc), 16'd1);
    repeat (3) @(posedge clk);
    #1;
    chk("abort_sb_empty", 16'(sb.size()), 16'd0);
  endtask
  initial begin
    @(negedge clk);
    chk("rst_busy", 16'(busy), 16'd0);
    chk("rst_done", 16'(done), 16'd0);
    chk("rst_instr", 16'(instr), 16'(IDL));
    chk("rst_imm", 16'(imm), 16'd0);
    chk("rst_pc", 16'(pc), 16'd0);
    @(posedge clk); #1;
    grst = 1'b1;
    @(posedge clk); #1;
    sb.push_back(dn());
    run(d_at, b_n, p_d);
    chk("empty_done_at", 16'(d_at), 16'd2);
    chk("empty_busy", 16'(b_n), 16'd1);
    prog(4'd0, 12'h135);
    prog(4'd1, 12'h162);
    prog(4'd2, 12'hF00);
    sb.push_back(ex(4'h3, 4'h5));
    sb.push_back(ex(4'h6, 4'h2));
    sb.push_back(dn());
    run(d_at, b_n, p_d);
    chk("exec2_done_at", 16'(d_at), 16'd4);
    chk("exec2_busy", 16'(b_n), 16'd3);
    prog(4'd0, 12'h403);
    prog(4'd1, 12'h110);
    prog(4'd2, 12'h501);
    prog(4'd3, 12'hF00);
    repeat (3) sb.push_back(ex(4'h1, 4'h0));
    sb.push_back(dn());
    run(d_at, b_n, p_d);
    chk("loop_done_at", 16'(d_at), 16'd9);
    chk("loop_busy", 16'(b_n), 16'd8);
    chk("loop_sb_empty", 16'(sb.size()), 16'd0);
    prog(4'd0, 12'h123);
    prog(4'd1, 12'h500);
    prog(4'd2, 12'hF00);
    repeat (16) sb.push_back(ex(4'h2, 4'h3));
    sb.push_back(dn());
    run(d_at, b_n, p_d);
    chk("wrap_done_at", 16'(d_at), 16'd34);
    chk("wrap_busy", 16'(b_n), 16'd33);
    prog(4'd0, 12'h141);
    prog(4'd1, 12'h307);
    prog(4'd2, 12'hF00);
    bus_in = 4'h0;
    sb.push_back(ex(4'h4, 4'h1));
    sb.push_back(dn());
    run(d_at, b_n, p_d);
    chk("jz_taken_pc", 16'(p_d), 16'd7);
    chk("jz_taken_done_at", 16'(d_at), 16'd4);
    bus_in = 4'h9;
    sb.push_back(ex(4'h4, 4'h1));
    sb.push_back(dn());
    run(d_at, b_n, p_d);
    chk("jz_not_taken_pc", 16'(p_d), 16'd2);
    bus_in = 4'h0;
    prog(4'd0, 12'h155);
    prog(4'd1, 12'h200);
    sb.push_back(ex(4'h5, 4'h5));
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    prog_we = 1'b1;
    prog_addr = 4'd0;
    prog_data = 12'hF00;
    @(posedge clk); #1;
    prog_we = 1'b0;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    chk("abort_busy_first", 16'(busy), 16'd0);
    @(posedge clk); #1;
    sb.push_back(ex(4'h5, 4'h5));
    abort_run();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("pre_rst_instr", 16'(instr), 16'h5);
    #1 grst = 1'b0;
    #1;
    chk("midrst_busy", 16'(busy), 16'd0);
    chk("midrst_done", 16'(done), 16'd0);
    chk("midrst_instr", 16'(instr), 16'(IDL));
    chk("midrst_imm", 16'(imm), 16'd0);
    chk("midrst_pc", 16'(pc), 16'd0);
    @(posedge clk);
    @(posedge clk); #1;
    grst = 1'b1;
    @(posedge clk); #1;
    prog(4'd0, 12'h201);
    sb.push_back(dn());
    run(d_at, b_n, p_d);
    chk("refill_done_at", 16'(d_at), 16'd3);
    chk("refill_busy", 16'(b_n), 16'd2);
    chk("final_sb_empty", 16'(sb.size()), 16'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
